// File: rtl/gol_generation_ctrl.sv
// gol_generation_ctrl: sequences generation updates, clears and seed loads for the Life cell array.
// Ports: clk_i/rst_ni (async active-low), run_sw_i level run enable, step/clear/seed_btn_i
// rising-edge requests, frame_done_i display sync, any_change_i still-life input,
// gen_en_o/clear_cells_o/seed_load_o single-cycle pulses, gen_count_o generations since
// clear/seed, running_o free-run indicator, halted_o still-life halt flag.
// Optional feature macro: STILL_DETECT_EN (halt when a generation changes nothing).
module gol_generation_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DIV_W    = 25,
  parameter int GEN_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_sw_i,
  input  logic             step_btn_i,
  input  logic             clear_btn_i,
  input  logic             seed_btn_i,
  input  logic             frame_done_i,
  input  logic             any_change_i,
  output logic             gen_en_o,
  output logic             clear_cells_o,
  output logic             seed_load_o,
  output logic [GEN_W-1:0] gen_count_o,
  output logic             running_o,
  output logic             halted_o
);
  typedef enum logic [2:0] {IDLE, RUN_WAIT, SYNC, UPDATE, CLEAR, SEED} state_e;
  state_e state_q;
  logic [DIV_W-1:0] div_q;
  logic [GEN_W-1:0] gen_q;
  logic from_run_q, step_q, clear_q, seed_q;
  logic gen_en_q, clear_cells_q, seed_load_q, running_q, halted_q;
  logic step_e, clear_e, seed_e;
  assign step_e  = step_btn_i & ~step_q;
  assign clear_e = clear_btn_i & ~clear_q;
  assign seed_e  = seed_btn_i & ~seed_q;
`ifdef STILL_DETECT_EN
  logic chk_q;
`else
  logic unused_any_change;
  assign unused_any_change = any_change_i;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q       <= IDLE;
      div_q         <= '0;
      gen_q         <= '0;
      from_run_q    <= 1'b0;
      step_q        <= 1'b0;
      clear_q       <= 1'b0;
      seed_q        <= 1'b0;
      gen_en_q      <= 1'b0;
      clear_cells_q <= 1'b0;
      seed_load_q   <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
`ifdef STILL_DETECT_EN
      chk_q         <= 1'b0;
`endif
    end else begin
      {clear_q, seed_q, step_q} <= {clear_btn_i, seed_btn_i, step_btn_i};
      gen_en_q      <= 1'b0;
      clear_cells_q <= 1'b0;
      seed_load_q   <= 1'b0;
      case (state_q)
        IDLE, RUN_WAIT: begin
          if (clear_e) begin
            state_q       <= CLEAR;
            clear_cells_q <= 1'b1;
            running_q     <= 1'b0;
          end else if (seed_e) begin
            state_q     <= SEED;
            seed_load_q <= 1'b1;
            running_q   <= 1'b0;
          end else if (state_q == IDLE) begin
            if (step_e && !halted_q) begin
              state_q    <= SYNC;
              from_run_q <= 1'b0;
            end else if (run_sw_i && !halted_q) begin
              state_q   <= RUN_WAIT;
              div_q     <= '0;
              running_q <= 1'b1;
            end
          end else if (!run_sw_i) begin
            state_q   <= IDLE;
            div_q     <= '0;
            running_q <= 1'b0;
          end else begin
            // divider reaches TICK_DIV-1 as SYNC is entered, giving a TICK_DIV+1 cycle period
            div_q <= div_q + DIV_W'(1);
            if (div_q == DIV_W'(TICK_DIV - 2)) begin
              state_q    <= SYNC;
              from_run_q <= 1'b1;
            end
          end
        end
        SYNC: begin
          if (clear_e) begin
            state_q       <= CLEAR;
            clear_cells_q <= 1'b1;
            running_q     <= 1'b0;
          end else if (from_run_q && !run_sw_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end else if (frame_done_i) begin
            state_q  <= UPDATE;
            gen_en_q <= 1'b1;
          end
        end
        UPDATE: begin
          gen_q     <= gen_q + GEN_W'(1);
          state_q   <= run_sw_i ? RUN_WAIT : IDLE;
          running_q <= run_sw_i;
          div_q     <= '0;
        end
        CLEAR, SEED: begin
          gen_q    <= '0;
          halted_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef STILL_DETECT_EN
      // any_change reflects the generation latched on the previous cycle's gen_en
      chk_q <= (state_q == UPDATE);
      if (chk_q && !any_change_i && !clear_e && !seed_e) begin
        halted_q  <= 1'b1;
        state_q   <= IDLE;
        running_q <= 1'b0;
        div_q     <= '0;
      end
`endif
    end
  assign gen_en_o      = gen_en_q;
  assign clear_cells_o = clear_cells_q;
  assign seed_load_o   = seed_load_q;
  assign gen_count_o   = gen_q;
  assign running_o     = running_q;
  assign halted_o      = halted_q;
endmodule

// File: tb/tb_gol_generation_ctrl.sv
// tb_gol_generation_ctrl: directed self-checking bench for gol_generation_ctrl (TICK_DIV=4, GEN_W=4).
module tb_gol_generation_ctrl;
  localparam int GEN_W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic run_sw = 1'b0, step_btn = 1'b0, clear_btn = 1'b0, seed_btn = 1'b0;
  logic frame_done = 1'b0, any_change = 1'b0;
  logic gen_en, clear_cells, seed_load, running, halted;
  logic [GEN_W-1:0] gen_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  gol_generation_ctrl #(.TICK_DIV(4), .DIV_W(3), .GEN_W(GEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_sw_i(run_sw), .step_btn_i(step_btn),
    .clear_btn_i(clear_btn), .seed_btn_i(seed_btn), .frame_done_i(frame_done),
    .any_change_i(any_change), .gen_en_o(gen_en), .clear_cells_o(clear_cells),
    .seed_load_o(seed_load), .gen_count_o(gen_count), .running_o(running),
    .halted_o(halted)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick();
      pulses += int'(gen_en);
    end
  endtask
  task automatic wait_gen(input int n, input int budget);
    int seen = 0, c = 0;
    while (seen < n && c < budget) begin
      tick();
      c++;
      if (gen_en) seen++;
    end
    check("gen_budget", seen, n);
  endtask
  task automatic do_clear();
    clear_btn = 1'b1;
    tick();
    check("clr_pulse", clear_cells, 1);
    clear_btn = 1'b0;
    tick();
    check("clr_cnt", gen_count, 0);
  endtask
  initial begin
    int p, last;
    run_sw = 1'b1; step_btn = 1'b1; clear_btn = 1'b1; seed_btn = 1'b1;
    frame_done = 1'b1; any_change = 1'b1;
    #23;
    check("rst_gen_en", gen_en, 0);
    check("rst_clear", clear_cells, 0);
    check("rst_seed", seed_load, 0);
    check("rst_count", gen_count, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    run_sw = 1'b0; step_btn = 1'b0; clear_btn = 1'b0; seed_btn = 1'b0;
    frame_done = 1'b0; any_change = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_count", gen_count, 0);
    check("idle_running", running, 0);
    check("idle_gen_en", gen_en, 0);
    frame_done = 1'b1;
    step_btn = 1'b1;
    tick();
    check("step_n1", gen_en, 0);
    tick();
    check("step_n2", gen_en, 1);
    check("step_cnt_during", gen_count, 0);
    tick();
    check("step_n3", gen_en, 0);
    check("step_cnt", gen_count, 1);
    step_btn = 1'b0;
    ticks(10, p);
    check("step_once", p, 0);
    check("step_cnt_hold", gen_count, 1);
    do_clear();
    run_sw = 1'b1;
    p = 0;
    last = 0;
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (gen_en) begin
        p++;
        if (last != 0) check("run_period", k - last, 5);
        else check("run_first", k, 5);
        last = k;
      end
    end
    check("run_pulses", p, 8);
    check("run_count", gen_count, 8);
    check("run_running", running, 1);
    run_sw = 1'b0;
    ticks(20, p);
    check("run_stop", p, 0);
    check("stop_running", running, 0);
    check("stop_count", gen_count, 8);
    do_clear();
    run_sw = 1'b1;
    frame_done = 1'b0;
    ticks(12, p);
    check("stall_gen", p, 0);
    check("stall_running", running, 1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("fd_pulse", gen_en, 1);
    tick();
    check("fd_single", gen_en, 0);
    check("fd_count", gen_count, 1);
    ticks(12, p);
    check("stall_again", p, 0);
    frame_done = 1'b1;
    wait_gen(14, 200);
    tick();
    check("cnt15", gen_count, 15);
    wait_gen(1, 50);
    tick();
    check("wrap", gen_count, 0);
    run_sw = 1'b0;
    frame_done = 1'b0;
    ticks(10, p);
    check("wrap_stop", p, 0);
    run_sw = 1'b1;
    ticks(8, p);
    frame_done = 1'b1;
    clear_btn = 1'b1;
    tick();
    check("sync_clear", clear_cells, 1);
    check("sync_clear_gen", gen_en, 0);
    run_sw = 1'b0;
    clear_btn = 1'b0;
    ticks(5, p);
    check("sync_clear_after", p, 0);
    check("sync_clear_run", running, 0);
    run_sw = 1'b1;
    frame_done = 1'b0;
    ticks(8, p);
    run_sw = 1'b0;
    frame_done = 1'b1;
    ticks(6, p);
    check("sync_abort", p, 0);
    check("sync_abort_run", running, 0);
    step_btn = 1'b1;
    ticks(3, p);
    step_btn = 1'b0;
    check("pre_cs_pulse", p, 1);
    check("pre_cs_count", gen_count, 1);
    tick();
    clear_btn = 1'b1;
    step_btn = 1'b1;
    tick();
    check("cs_clear", clear_cells, 1);
    check("cs_gen", gen_en, 0);
    clear_btn = 1'b0;
    step_btn = 1'b0;
    tick();
    check("cs_count", gen_count, 0);
    ticks(6, p);
    check("cs_no_gen", p, 0);
    step_btn = 1'b1;
    ticks(3, p);
    step_btn = 1'b0;
    tick();
    seed_btn = 1'b1;
    tick();
    check("seed_pulse", seed_load, 1);
    check("seed_not_clear", clear_cells, 0);
    seed_btn = 1'b0;
    tick();
    check("seed_done", seed_load, 0);
    check("seed_count", gen_count, 0);
`ifdef STILL_DETECT_EN
    run_sw = 1'b1;
    frame_done = 1'b1;
    any_change = 1'b0;
    wait_gen(1, 50);
    tick();
    tick();
    check("halt_set", halted, 1);
    check("halt_running", running, 0);
    step_btn = 1'b1;
    ticks(20, p);
    step_btn = 1'b0;
    check("halt_no_gen", p, 0);
    run_sw = 1'b0;
    seed_btn = 1'b1;
    tick();
    check("halt_seed", seed_load, 1);
    seed_btn = 1'b0;
    tick();
    check("halt_release", halted, 0);
`else
    run_sw = 1'b1;
    frame_done = 1'b1;
    any_change = 1'b0;
    wait_gen(2, 50);
    tick();
    check("no_halt", halted, 0);
    run_sw = 1'b0;
    ticks(8, p);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
